// File: rtl/game_round_sequencer.sv
// game_round_sequencer: whack-a-mole round controller (IDLE/COUNTDOWN/PLAY/OVER)
// with the per-mole window timer and score / miss / level bookkeeping.
`default_nettype none

module game_round_sequencer #(
  parameter int TICKS_PER_SEC  = 100,
  parameter int COUNTDOWN_SECS = 3,
  parameter int GAME_SECS      = 30,
  parameter int MAX_MISS       = 3,
  parameter int BASE_WINDOW    = 200,
  parameter int WINDOW_STEP    = 25,
  parameter int WINDOW_MIN     = 50,
  parameter int LEVEL_HITS     = 5,
  parameter int MAX_LEVEL      = 7
) (
  input  logic       clk_game,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       hit_pulse,
  input  logic       start_timer,
  output logic       enable,
  output logic       timeout_pulse,
  output logic [1:0] state,
  output logic [7:0] score,
  output logic [3:0] misses,
  output logic [2:0] level,
  output logic [5:0] secs_left,
  output logic       game_over
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_COUNTDOWN = 2'd1;
  localparam logic [1:0] S_PLAY      = 2'd2;
  localparam logic [1:0] S_OVER      = 2'd3;

  localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int HIT_W  = (LEVEL_HITS > 1) ? $clog2(LEVEL_HITS) : 1;
  localparam int WIN_W  = 16;

  logic [1:0]        state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [5:0]        secs_q, secs_d;
  logic [7:0]        score_q, score_d;
  logic [3:0]        misses_q, misses_d;
  logic [2:0]        level_q, level_d;
  logic [HIT_W-1:0]  hits_q, hits_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic              armed_q, armed_d;
  logic              timeout_q, timeout_d;
  logic              enable_q, enable_d;
  logic              game_over_q, game_over_d;

  logic              tick_wrap;
  logic              secs_expire;
  logic              miss_limit;
  logic [WIN_W-1:0]  win_prod;
  logic [WIN_W-1:0]  win_load;

  assign tick_wrap   = (tick_q == TICK_W'(TICKS_PER_SEC - 1));
  assign secs_expire = tick_wrap && (secs_q == 6'd1);
  assign miss_limit  = (misses_q >= 4'(MAX_MISS));

  // Window shrinks per level but never below the floor; compare before subtracting.
  assign win_prod = WIN_W'(level_q) * WIN_W'(WINDOW_STEP);
  assign win_load = ((win_prod + WIN_W'(WINDOW_MIN)) >= WIN_W'(BASE_WINDOW)) ?
                    WIN_W'(WINDOW_MIN) : (WIN_W'(BASE_WINDOW) - win_prod);

  always_ff @(posedge clk_game or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_OVER: if (start_btn) state_d = S_COUNTDOWN;
      S_COUNTDOWN:    if (secs_expire) state_d = S_PLAY;
      S_PLAY:         if (miss_limit || secs_expire) state_d = S_OVER;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    enable_d    = (state_d == S_PLAY);
    game_over_d = (state_d == S_OVER);
  end

  always_comb begin
    tick_d    = tick_q;
    secs_d    = secs_q;
    score_d   = score_q;
    misses_d  = misses_q;
    level_d   = level_q;
    hits_d    = hits_q;
    win_d     = win_q;
    armed_d   = armed_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_btn) begin
          score_d  = '0;
          misses_d = '0;
          level_d  = '0;
          hits_d   = '0;
          secs_d   = 6'(COUNTDOWN_SECS);
          tick_d   = '0;
          armed_d  = 1'b0;
        end
      end
      S_COUNTDOWN: begin
        tick_d = tick_wrap ? '0 : (tick_q + TICK_W'(1));
        if (secs_expire) begin
          secs_d = 6'(GAME_SECS);
        end else if (tick_wrap) begin
          secs_d = secs_q - 6'd1;
        end
      end
      S_PLAY: begin
        if (state_d == S_OVER) begin
          armed_d = 1'b0;
        end else begin
          tick_d = tick_wrap ? '0 : (tick_q + TICK_W'(1));
          if (tick_wrap) secs_d = secs_q - 6'd1;
          // A reload or a hit pre-empts an expiry landing in the same cycle.
          if (start_timer) begin
            armed_d = 1'b1;
            win_d   = win_load;
          end else if (hit_pulse) begin
            armed_d = 1'b0;
          end else if (armed_q) begin
            win_d = win_q - WIN_W'(1);
            if (win_q == WIN_W'(1)) begin
              armed_d   = 1'b0;
              timeout_d = 1'b1;
              misses_d  = misses_q + 4'd1;
            end
          end
          if (hit_pulse) begin
            if (score_q != 8'hFF) score_d = score_q + 8'd1;
            if (hits_q == HIT_W'(LEVEL_HITS - 1)) begin
              hits_d = '0;
              if (level_q != 3'(MAX_LEVEL)) level_d = level_q + 3'd1;
            end else begin
              hits_d = hits_q + HIT_W'(1);
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_game or negedge rst_n) begin
    if (!rst_n) begin
      tick_q      <= '0;
      secs_q      <= '0;
      score_q     <= '0;
      misses_q    <= '0;
      level_q     <= '0;
      hits_q      <= '0;
      win_q       <= '0;
      armed_q     <= 1'b0;
      timeout_q   <= 1'b0;
      enable_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      tick_q      <= tick_d;
      secs_q      <= secs_d;
      score_q     <= score_d;
      misses_q    <= misses_d;
      level_q     <= level_d;
      hits_q      <= hits_d;
      win_q       <= win_d;
      armed_q     <= armed_d;
      timeout_q   <= timeout_d;
      enable_q    <= enable_d;
      game_over_q <= game_over_d;
    end
  end

  assign state         = state_q;
  assign score         = score_q;
  assign misses        = misses_q;
  assign level         = level_q;
  assign secs_left     = secs_q;
  assign timeout_pulse = timeout_q;
  assign enable        = enable_q;
  assign game_over     = game_over_q;

endmodule

`default_nettype wire

// File: tb/tb_game_round_sequencer.sv
// Bench for game_round_sequencer: directed scenarios plus randomized play
// checked against an absolute-deadline reference model.
`default_nettype none

module tb_game_round_sequencer;

  localparam int T    = 10;
  localparam int CD   = 2;
  localparam int G    = 63;
  localparam int GS   = 5;
  localparam int MAXM = 3;
  localparam int BASE = 200;
  localparam int STEP = 25;
  localparam int WMIN = 50;
  localparam int LH   = 5;
  localparam int MAXL = 7;

  logic clk_game = 1'b0;
  logic rst_n, start_btn, hit_pulse, start_timer;

  logic       enable, timeout_pulse, game_over;
  logic [1:0] state;
  logic [7:0] score;
  logic [3:0] misses;
  logic [2:0] level;
  logic [5:0] secs_left;

  logic       s_enable, s_timeout_pulse, s_game_over;
  logic [1:0] s_state;
  logic [7:0] s_score;
  logic [3:0] s_misses;
  logic [2:0] s_level;
  logic [5:0] s_secs_left;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state (for the long-round instance)
  logic [1:0] m_state;
  logic [7:0] m_score;
  logic [3:0] m_misses;
  logic [2:0] m_level;
  logic [5:0] m_secs;
  logic       m_timeout;
  int         m_hits, m_deadline, m_end;
  int         cyc = 0;

  always #5 clk_game = ~clk_game;

  game_round_sequencer #(
    .TICKS_PER_SEC(T), .COUNTDOWN_SECS(CD), .GAME_SECS(G), .MAX_MISS(MAXM),
    .BASE_WINDOW(BASE), .WINDOW_STEP(STEP), .WINDOW_MIN(WMIN),
    .LEVEL_HITS(LH), .MAX_LEVEL(MAXL)
  ) dut (
    .clk_game(clk_game), .rst_n(rst_n), .start_btn(start_btn),
    .hit_pulse(hit_pulse), .start_timer(start_timer),
    .enable(enable), .timeout_pulse(timeout_pulse), .state(state),
    .score(score), .misses(misses), .level(level),
    .secs_left(secs_left), .game_over(game_over)
  );

  game_round_sequencer #(
    .TICKS_PER_SEC(T), .COUNTDOWN_SECS(CD), .GAME_SECS(GS), .MAX_MISS(MAXM),
    .BASE_WINDOW(BASE), .WINDOW_STEP(STEP), .WINDOW_MIN(WMIN),
    .LEVEL_HITS(LH), .MAX_LEVEL(MAXL)
  ) dut_short (
    .clk_game(clk_game), .rst_n(rst_n), .start_btn(start_btn),
    .hit_pulse(hit_pulse), .start_timer(start_timer),
    .enable(s_enable), .timeout_pulse(s_timeout_pulse), .state(s_state),
    .score(s_score), .misses(s_misses), .level(s_level),
    .secs_left(s_secs_left), .game_over(s_game_over)
  );

  function automatic int window_for(int lv);
    int w;
    w = BASE - lv * STEP;
    return (w < WMIN) ? WMIN : w;
  endfunction

  task automatic model_reset();
    m_state = 2'd0; m_score = 8'd0; m_misses = 4'd0; m_level = 3'd0;
    m_secs = 6'd0; m_timeout = 1'b0; m_hits = 0; m_deadline = -1; m_end = 0;
  endtask

  // Phases end at absolute cycle numbers; seconds left is the remaining time rounded up.
  task automatic model_update();
    cyc++;
    m_timeout = 1'b0;
    case (m_state)
      2'd0, 2'd3: begin
        if (start_btn) begin
          m_state = 2'd1; m_score = 8'd0; m_misses = 4'd0; m_level = 3'd0;
          m_hits = 0; m_deadline = -1; m_end = cyc + CD * T; m_secs = 6'(CD);
        end
      end
      2'd1: begin
        if (cyc == m_end) begin
          m_state = 2'd2; m_end = cyc + G * T; m_secs = 6'(G);
        end else begin
          m_secs = 6'((m_end - cyc + T - 1) / T);
        end
      end
      default: begin
        if (int'(m_misses) >= MAXM || cyc == m_end) begin
          m_state = 2'd3; m_deadline = -1;
        end else begin
          m_secs = 6'((m_end - cyc + T - 1) / T);
          if (start_timer) m_deadline = cyc + window_for(int'(m_level));
          else if (hit_pulse) m_deadline = -1;
          else if (m_deadline == cyc) begin
            m_timeout = 1'b1; m_misses = m_misses + 4'd1; m_deadline = -1;
          end
          if (hit_pulse) begin
            if (m_score != 8'd255) m_score = m_score + 8'd1;
            m_hits++;
            if (m_hits == LH) begin
              m_hits = 0;
              if (int'(m_level) < MAXL) m_level = m_level + 3'd1;
            end
          end
        end
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk_game);
    if (!rst_n) model_reset();
    else model_update();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_btn = 1'b0; hit_pulse = 1'b0; start_timer = 1'b0;
    model_reset();
    repeat (2) step();
    n_checks++;
    if ({state, score, misses, level, secs_left, enable, game_over, timeout_pulse} !== '0)
      $display("FAIL reset_main: got %h, expected 0",
               {state, score, misses, level, secs_left, enable, game_over, timeout_pulse});
    else n_pass++;
    n_checks++;
    if ({s_state, s_score, s_misses, s_level, s_secs_left, s_enable, s_game_over, s_timeout_pulse} !== '0)
      $display("FAIL reset_short: got %h, expected 0",
               {s_state, s_score, s_misses, s_level, s_secs_left, s_enable, s_game_over, s_timeout_pulse});
    else n_pass++;
    rst_n = 1'b1;
    step();
    n_checks++;
    if (state !== 2'd0) $display("FAIL idle_hold: got %0d, expected 0", state); else n_pass++;
  endtask

  task automatic test_countdown();
    start_btn = 1'b1; step(); start_btn = 1'b0;
    n_checks++;
    if (state !== 2'd1) $display("FAIL cd_state: got %0d, expected 1", state); else n_pass++;
    n_checks++;
    if (secs_left !== 6'd2 || s_secs_left !== 6'd2)
      $display("FAIL cd_secs: got %0d/%0d, expected 2/2", secs_left, s_secs_left); else n_pass++;
    for (int i = 0; i < 19; i++) begin
      start_btn = (i == 5);
      step();
    end
    start_btn = 1'b0;
    n_checks++;
    if (state !== 2'd1 || secs_left !== 6'd1)
      $display("FAIL cd_late: got state %0d secs %0d, expected 1/1", state, secs_left); else n_pass++;
    step();
    n_checks++;
    if (state !== 2'd2 || enable !== 1'b1 || secs_left !== 6'd63)
      $display("FAIL play_entry: got state %0d en %0d secs %0d, expected 2/1/63", state, enable, secs_left);
    else n_pass++;
    n_checks++;
    if (s_state !== 2'd2 || s_enable !== 1'b1 || s_secs_left !== 6'd5)
      $display("FAIL play_entry_short: got state %0d en %0d secs %0d, expected 2/1/5",
               s_state, s_enable, s_secs_left);
    else n_pass++;
  endtask

  task automatic test_round_timeout();
    int over_at = -1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (s_state == 2'd3 && over_at < 0) over_at = i;
    end
    n_checks++;
    if (over_at != 50) $display("FAIL round_end_time: got %0d, expected 50", over_at); else n_pass++;
    n_checks++;
    if (s_game_over !== 1'b1 || s_enable !== 1'b0 || s_secs_left !== 6'd1)
      $display("FAIL round_end_outs: got go %0d en %0d secs %0d, expected 1/0/1",
               s_game_over, s_enable, s_secs_left);
    else n_pass++;
    n_checks++;
    if (state !== 2'd2 || secs_left !== 6'd57)
      $display("FAIL long_round_secs: got state %0d secs %0d, expected 2/57", state, secs_left);
    else n_pass++;
  endtask

  task automatic test_window_timeout();
    int first = -1, cnt = 0;
    start_timer = 1'b1; step(); start_timer = 1'b0;
    for (int i = 1; i <= 205; i++) begin
      step();
      if (timeout_pulse === 1'b1) begin cnt++; if (first < 0) first = i; end
    end
    n_checks++;
    if (first != 200 || cnt != 1)
      $display("FAIL window_l0: got at %0d count %0d, expected 200/1", first, cnt); else n_pass++;
    n_checks++;
    if (misses !== 4'd1) $display("FAIL miss_count1: got %0d, expected 1", misses); else n_pass++;
  endtask

  task automatic test_level_up();
    int first = -1, cnt = 0, over_at = -1;
    for (int k = 0; k < 5; k++) begin
      start_timer = 1'b1; step(); start_timer = 1'b0;
      hit_pulse = 1'b1; step(); hit_pulse = 1'b0;
    end
    n_checks++;
    if (score !== 8'd5 || level !== 3'd1 || misses !== 4'd1)
      $display("FAIL level1: got score %0d level %0d misses %0d, expected 5/1/1", score, level, misses);
    else n_pass++;
    start_timer = 1'b1; step(); start_timer = 1'b0;
    for (int i = 1; i <= 180; i++) begin
      step();
      if (timeout_pulse === 1'b1) begin cnt++; if (first < 0) first = i; end
    end
    n_checks++;
    if (first != 175 || cnt != 1 || misses !== 4'd2)
      $display("FAIL window_l1: got at %0d count %0d misses %0d, expected 175/1/2", first, cnt, misses);
    else n_pass++;
    hit_pulse = 1'b1; repeat (30) step(); hit_pulse = 1'b0;
    n_checks++;
    if (level !== 3'd7 || score !== 8'd35)
      $display("FAIL level7: got level %0d score %0d, expected 7/35", level, score); else n_pass++;
    first = -1; cnt = 0;
    start_timer = 1'b1; step(); start_timer = 1'b0;
    for (int i = 1; i <= 55; i++) begin
      step();
      if (timeout_pulse === 1'b1) begin cnt++; if (first < 0) first = i; end
      if (state == 2'd3 && over_at < 0) over_at = i;
    end
    n_checks++;
    if (first != 50 || cnt != 1)
      $display("FAIL window_floor: got at %0d count %0d, expected 50/1", first, cnt); else n_pass++;
    n_checks++;
    if (over_at != 51) $display("FAIL miss_limit_time: got %0d, expected 51", over_at); else n_pass++;
    n_checks++;
    if (game_over !== 1'b1 || enable !== 1'b0 || misses !== 4'd3 || level !== 3'd7 || score !== 8'd35)
      $display("FAIL over_outs: got go %0d en %0d misses %0d level %0d score %0d, expected 1/0/3/7/35",
               game_over, enable, misses, level, score);
    else n_pass++;
  endtask

  task automatic test_over_restart();
    int cnt = 0;
    start_timer = 1'b1; hit_pulse = 1'b1; step(); start_timer = 1'b0; hit_pulse = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (timeout_pulse === 1'b1) cnt++;
    end
    n_checks++;
    if (cnt != 0 || score !== 8'd35 || state !== 2'd3)
      $display("FAIL over_ignore: got pulses %0d score %0d state %0d, expected 0/35/3", cnt, score, state);
    else n_pass++;
    start_btn = 1'b1; step(); start_btn = 1'b0;
    n_checks++;
    if (state !== 2'd1 || score !== 8'd0 || misses !== 4'd0 || level !== 3'd0 ||
        game_over !== 1'b0 || secs_left !== 6'd2)
      $display("FAIL restart: got state %0d score %0d misses %0d level %0d go %0d secs %0d, expected 1/0/0/0/0/2",
               state, score, misses, level, game_over, secs_left);
    else n_pass++;
    repeat (20) step();
    n_checks++;
    if (state !== 2'd2 || enable !== 1'b1)
      $display("FAIL restart_play: got state %0d en %0d, expected 2/1", state, enable); else n_pass++;
  endtask

  task automatic test_simultaneous();
    int first = -1, cnt = 0, over_at = -1;
    start_timer = 1'b1; step(); start_timer = 1'b0;
    repeat (199) step();
    hit_pulse = 1'b1; step(); hit_pulse = 1'b0;
    n_checks++;
    if (timeout_pulse !== 1'b0 || score !== 8'd1 || misses !== 4'd0)
      $display("FAIL hit_at_expiry: got to %0d score %0d misses %0d, expected 0/1/0",
               timeout_pulse, score, misses);
    else n_pass++;
    step();
    n_checks++;
    if (timeout_pulse !== 1'b0) $display("FAIL hit_disarm: got %0d, expected 0", timeout_pulse); else n_pass++;
    start_timer = 1'b1; step(); start_timer = 1'b0;
    repeat (199) step();
    start_timer = 1'b1; step(); start_timer = 1'b0;
    n_checks++;
    if (timeout_pulse !== 1'b0 || misses !== 4'd0)
      $display("FAIL reload_at_expiry: got to %0d misses %0d, expected 0/0", timeout_pulse, misses);
    else n_pass++;
    for (int i = 1; i <= 205; i++) begin
      step();
      if (timeout_pulse === 1'b1) begin cnt++; if (first < 0) first = i; end
    end
    n_checks++;
    if (first != 200 || cnt != 1 || misses !== 4'd1)
      $display("FAIL reload_window: got at %0d count %0d misses %0d, expected 200/1/1", first, cnt, misses);
    else n_pass++;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (state == 2'd3 && over_at < 0) over_at = i;
    end
    n_checks++;
    if (over_at != 22 || secs_left !== 6'd1 || game_over !== 1'b1)
      $display("FAIL time_over: got at %0d secs %0d go %0d, expected 22/1/1", over_at, secs_left, game_over);
    else n_pass++;
  endtask

  task automatic test_random();
    int hit_div, st_div;
    for (int blk = 0; blk < 8; blk++) begin
      hit_div = (blk % 2 == 0) ? 5 : 300;
      st_div  = (blk % 2 == 0) ? 8 : 120;
      for (int i = 0; i < 400; i++) begin
        start_btn   = ($urandom_range(39) == 0);
        hit_pulse   = ($urandom_range(hit_div - 1) == 0);
        start_timer = ($urandom_range(st_div - 1) == 0);
        step();
        n_checks++;
        if (state !== m_state) $display("FAIL rnd_state @%0d: got %0d, expected %0d", cyc, state, m_state);
        else n_pass++;
        n_checks++;
        if (score !== m_score) $display("FAIL rnd_score @%0d: got %0d, expected %0d", cyc, score, m_score);
        else n_pass++;
        n_checks++;
        if (misses !== m_misses) $display("FAIL rnd_misses @%0d: got %0d, expected %0d", cyc, misses, m_misses);
        else n_pass++;
        n_checks++;
        if (level !== m_level) $display("FAIL rnd_level @%0d: got %0d, expected %0d", cyc, level, m_level);
        else n_pass++;
        n_checks++;
        if (secs_left !== m_secs) $display("FAIL rnd_secs @%0d: got %0d, expected %0d", cyc, secs_left, m_secs);
        else n_pass++;
        n_checks++;
        if (timeout_pulse !== m_timeout)
          $display("FAIL rnd_timeout @%0d: got %0d, expected %0d", cyc, timeout_pulse, m_timeout);
        else n_pass++;
        n_checks++;
        if (enable !== (m_state == 2'd2))
          $display("FAIL rnd_enable @%0d: got %0d, expected %0d", cyc, enable, m_state == 2'd2);
        else n_pass++;
        n_checks++;
        if (game_over !== (m_state == 2'd3))
          $display("FAIL rnd_game_over @%0d: got %0d, expected %0d", cyc, game_over, m_state == 2'd3);
        else n_pass++;
      end
    end
    start_btn = 1'b0; hit_pulse = 1'b0; start_timer = 1'b0;
  endtask

  task automatic test_reset_midround();
    int cnt = 0;
    rst_n = 1'b0; #2; rst_n = 1'b1; model_reset();
    start_btn = 1'b1; step(); start_btn = 1'b0;
    repeat (20) step();
    n_checks++;
    if (state !== 2'd2) $display("FAIL pre_reset_play: got %0d, expected 2", state); else n_pass++;
    start_timer = 1'b1; step(); start_timer = 1'b0;
    repeat (50) step();
    rst_n = 1'b0; model_reset();
    #2;
    n_checks++;
    if ({state, score, misses, level, secs_left, enable, game_over, timeout_pulse} !== '0)
      $display("FAIL async_reset: got %h, expected 0",
               {state, score, misses, level, secs_left, enable, game_over, timeout_pulse});
    else n_pass++;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 260; i++) begin
      step();
      if (timeout_pulse === 1'b1) cnt++;
    end
    n_checks++;
    if (cnt != 0 || state !== 2'd0)
      $display("FAIL lost_timeout: got pulses %0d state %0d, expected 0/0", cnt, state); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_round_timeout();
    test_window_timeout();
    test_level_up();
    test_over_restart();
    test_simultaneous();
    test_random();
    test_reset_midround();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
